// File: rtl/mma_counter_pkg.sv
// Shared definitions for the multi-channel profiling counter: default sizes,
// channel mode encoding and the lane-offset helper for packed channel buses.
package mma_counter_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Low bit of channel idx inside a bus packed as [idx*width +: width].
    function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter lane: load, up/down step against a programmable limit, wrap or
// saturate at the boundary, terminal-count pulse and sticky overflow flag.
module counter_channel
    import mma_counter_pkg::*;
#(
    parameter int    WIDTH = DEF_WIDTH,
    parameter mode_e MODE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             clr,
    input  logic             tick,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg, tc_next;
    logic             ovf_reg, ovf_next;
    logic             step;
    logic             at_bound;

    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        ovf_next   = ovf_reg;
        at_bound   = 1'b0;
        // A load swallows the tick for this lane, so it can never raise a boundary.
        step       = tick & en & ~load;
        if (step) begin
            at_bound = up ? (count_reg >= limit) : (count_reg == '0);
        end
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            if (load) begin
                count_next = load_val;
            end else if (step) begin
                if (at_bound) begin
                    count_next = (MODE == MODE_SAT) ? count_reg : (up ? '0 : limit);
                end else begin
                    count_next = up ? count_reg + WIDTH'(1) : count_reg - WIDTH'(1);
                end
            end
            tc_next = at_bound;
            if (at_bound) begin
                ovf_next = 1'b1;
            end else if (ovf_clr) begin
                ovf_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (active) begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/multi_counter.sv
// CHANNELS independent counters driven by one shared prescaler; reset release
// is synchronised through two flops before any state may change.
module multi_counter
    import mma_counter_pkg::*;
#(
    parameter int                  PRESCALER = 1,
    parameter int                  WIDTH     = DEF_WIDTH,
    parameter int                  CHANNELS  = DEF_CHANNELS,
    parameter logic [CHANNELS-1:0] SATURATE  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      clr,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       up,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    input  logic [CHANNELS-1:0]       ovf_clr,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf,
    output logic                      tick
);

    localparam int             PW    = $clog2(PRESCALER) + 1;
    localparam logic [PW-1:0]  PLAST = PW'(PRESCALER - 1);

    logic [1:0]    sync_reg;
    logic          active;
    logic [PW-1:0] pcnt_reg;
    logic          tick_reg;
    logic          tick_now;

    assign active   = sync_reg[1];
    assign tick_now = active & run & ~clr & (pcnt_reg == PLAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 2'b00;
            pcnt_reg <= '0;
            tick_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
            if (active) begin
                if (clr) begin
                    pcnt_reg <= '0;
                    tick_reg <= 1'b0;
                end else begin
                    tick_reg <= tick_now;
                    // A stopped prescaler keeps its phase rather than restarting.
                    if (run) begin
                        pcnt_reg <= tick_now ? '0 : pcnt_reg + PW'(1);
                    end
                end
            end
        end
    end

    assign tick = tick_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            counter_channel #(
                .WIDTH (WIDTH),
                .MODE  (SATURATE[gi] ? MODE_SAT : MODE_WRAP)
            ) u_chan (
                .clk      (clk),
                .reset    (reset),
                .active   (active),
                .clr      (clr),
                .tick     (tick_now),
                .en       (en[gi]),
                .up       (up[gi]),
                .load     (load[gi]),
                .load_val (load_val[lane_lo(gi, WIDTH) +: WIDTH]),
                .limit    (limit[lane_lo(gi, WIDTH) +: WIDTH]),
                .ovf_clr  (ovf_clr[gi]),
                .count    (count[lane_lo(gi, WIDTH) +: WIDTH]),
                .tc       (tc[gi]),
                .ovf      (ovf[gi])
            );
        end
    endgenerate

endmodule
